// File: rtl/basic_block_window.sv
// Regex execution unit for one thread against a window of 2^CC_ID_BITS characters.
// Fetches the instruction at pc, executes it, and emits up to two successor threads or an accept pulse.
module basic_block_window #(
    parameter int PC_WIDTH          = 8,
    parameter int CHARACTER_WIDTH   = 8,
    parameter int MEMORY_WIDTH      = 16,
    parameter int MEMORY_ADDR_WIDTH = 11,
    parameter int CC_ID_BITS        = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [CHARACTER_WIDTH*(2**CC_ID_BITS)-1:0]  current_characters,
    input  logic                                        input_pc_valid,
    input  logic [PC_WIDTH-1:0]                         input_pc,
    input  logic [CC_ID_BITS-1:0]                       input_cc_id,
    output logic                                        input_pc_ready,
    input  logic                                        memory_ready,
    output logic [MEMORY_ADDR_WIDTH-1:0]                memory_addr,
    input  logic [MEMORY_WIDTH-1:0]                     memory_data,
    output logic                                        memory_valid,
    output logic                                        output_pc_valid,
    output logic [PC_WIDTH-1:0]                         output_pc,
    output logic [CC_ID_BITS-1:0]                       output_cc_id,
    output logic                                        output_pc_is_directed_to_current,
    input  logic                                        output_pc_ready,
    output logic                                        accepts
);

    localparam int WINDOW                 = 2 ** CC_ID_BITS;
    localparam int OPCODE_WIDTH           = 3;
    localparam int INSTRUCTION_DATA_WIDTH = MEMORY_WIDTH - OPCODE_WIDTH;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        OP_ACCEPT                = 3'd0,
        OP_SPLIT                 = 3'd1,
        OP_MATCH_CHAR            = 3'd2,
        OP_JMP                   = 3'd3,
        OP_END_WITHOUT_ACCEPTING = 3'd4,
        OP_MATCH_ANY             = 3'd5,
        OP_ACCEPT_PARTIAL        = 3'd6,
        OP_NOT_MATCH_CHAR        = 3'd7
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EXEC,
        ST_OUT1,
        ST_OUT2
    } state_t;

    state_t                      state;
    logic [PC_WIDTH-1:0]         pc_reg;
    logic [CC_ID_BITS-1:0]       cc_reg;
    logic [MEMORY_WIDTH-1:0]     instr_reg;

    logic [CHARACTER_WIDTH-1:0]  window [WINDOW];
    logic [CHARACTER_WIDTH-1:0]  ch;
    opcode_t                     fetched_op;
    opcode_t                     exec_op;
    logic [INSTRUCTION_DATA_WIDTH-1:0] exec_data;
    logic [PC_WIDTH-1:0]         pc_next;
    logic [CC_ID_BITS-1:0]       cc_next;
    logic                        accept_now;
    logic                        consume_emit;
    logic                        unused_instr;

    always_comb begin
        for (int k = 0; k < WINDOW; k++) begin
            window[k] = current_characters[k*CHARACTER_WIDTH +: CHARACTER_WIDTH];
        end
    end

    assign ch         = window[cc_reg];
    assign fetched_op = opcode_t'(memory_data[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
    assign exec_op    = opcode_t'(instr_reg[MEMORY_WIDTH-1 -: OPCODE_WIDTH]);
    assign exec_data  = instr_reg[INSTRUCTION_DATA_WIDTH-1:0];
    assign pc_next    = pc_reg + PC_WIDTH'(1);
    assign cc_next    = cc_reg + CC_ID_BITS'(1);
    // Data bits above the pc/character fields are reserved in this instruction set.
    assign unused_instr = ^instr_reg;

    // accepts is registered on the edge that latches the word, so it is decided from memory_data directly.
    assign accept_now = (fetched_op == OP_ACCEPT && ch == '0) || (fetched_op == OP_ACCEPT_PARTIAL);

    always_comb begin
        consume_emit = 1'b0;
        case (exec_op)
            OP_MATCH_CHAR:     consume_emit = (ch == exec_data[CHARACTER_WIDTH-1:0]);
            OP_NOT_MATCH_CHAR: consume_emit = (ch != exec_data[CHARACTER_WIDTH-1:0]);
            OP_MATCH_ANY:      consume_emit = 1'b1;
            default:           consume_emit = 1'b0;
        endcase
    end

    // NOTE: every state and output register uses non-blocking assignment so all update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                            <= ST_IDLE;
            pc_reg                           <= '0;
            cc_reg                           <= '0;
            instr_reg                        <= '0;
            input_pc_ready                   <= 1'b1;
            memory_valid                     <= 1'b0;
            memory_addr                      <= '0;
            output_pc_valid                  <= 1'b0;
            output_pc                        <= '0;
            output_cc_id                     <= '0;
            output_pc_is_directed_to_current <= 1'b0;
            accepts                          <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (input_pc_valid) begin
                        pc_reg         <= input_pc;
                        cc_reg         <= input_cc_id;
                        memory_addr    <= MEMORY_ADDR_WIDTH'(input_pc);
                        memory_valid   <= 1'b1;
                        input_pc_ready <= 1'b0;
                        state          <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (memory_ready) begin
                        memory_valid <= 1'b0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    instr_reg <= memory_data;
                    accepts   <= accept_now;
                    state     <= ST_EXEC;
                end
                ST_EXEC: begin
                    accepts                          <= 1'b0;
                    output_cc_id                     <= cc_reg;
                    output_pc_is_directed_to_current <= 1'b1;
                    if (consume_emit) begin
                        output_pc_valid                  <= 1'b1;
                        output_pc                        <= pc_next;
                        output_cc_id                     <= cc_next;
                        output_pc_is_directed_to_current <= (cc_next != '0);
                        state                            <= ST_OUT1;
                    end else if (exec_op == OP_JMP) begin
                        output_pc_valid <= 1'b1;
                        output_pc       <= exec_data[PC_WIDTH-1:0];
                        state           <= ST_OUT1;
                    end else if (exec_op == OP_SPLIT) begin
                        output_pc_valid <= 1'b1;
                        output_pc       <= pc_next;
                        state           <= ST_OUT1;
                    end else begin
                        input_pc_ready <= 1'b1;
                        state          <= ST_IDLE;
                    end
                end
                ST_OUT1: begin
                    if (output_pc_ready) begin
                        if (exec_op == OP_SPLIT) begin
                            output_pc <= exec_data[PC_WIDTH-1:0];
                            state     <= ST_OUT2;
                        end else begin
                            output_pc_valid <= 1'b0;
                            input_pc_ready  <= 1'b1;
                            state           <= ST_IDLE;
                        end
                    end
                end
                ST_OUT2: begin
                    if (output_pc_ready) begin
                        output_pc_valid <= 1'b0;
                        input_pc_ready  <= 1'b1;
                        state           <= ST_IDLE;
                    end
                end
                default: begin
                    output_pc_valid <= 1'b0;
                    memory_valid    <= 1'b0;
                    input_pc_ready  <= 1'b1;
                    state           <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_basic_block_window.sv
// Scoreboard bench for basic_block_window: expected successors are queued per thread
// and compared, field by field, every cycle the DUT presents them.
module tb_basic_block_window;

    localparam logic [2:0] OP_ACCEPT         = 3'd0;
    localparam logic [2:0] OP_SPLIT          = 3'd1;
    localparam logic [2:0] OP_MATCH_CHAR     = 3'd2;
    localparam logic [2:0] OP_JMP            = 3'd3;
    localparam logic [2:0] OP_END            = 3'd4;
    localparam logic [2:0] OP_MATCH_ANY      = 3'd5;
    localparam logic [2:0] OP_ACCEPT_PARTIAL = 3'd6;
    localparam logic [2:0] OP_NOT_MATCH_CHAR = 3'd7;

    typedef struct {
        logic [7:0] pc;
        logic [1:0] cc;
        logic       dir;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] current_characters = '0;
    logic        input_pc_valid = 1'b0;
    logic [7:0]  input_pc = '0;
    logic [1:0]  input_cc_id = '0;
    logic        input_pc_ready;
    logic        memory_ready = 1'b0;
    logic [10:0] memory_addr;
    logic [15:0] memory_data = '0;
    logic        memory_valid;
    logic        output_pc_valid;
    logic [7:0]  output_pc;
    logic [1:0]  output_cc_id;
    logic        output_pc_is_directed_to_current;
    logic        output_pc_ready = 1'b0;
    logic        accepts;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    basic_block_window dut (
        .clk                              (clk),
        .reset                            (reset),
        .current_characters               (current_characters),
        .input_pc_valid                   (input_pc_valid),
        .input_pc                         (input_pc),
        .input_cc_id                      (input_cc_id),
        .input_pc_ready                   (input_pc_ready),
        .memory_ready                     (memory_ready),
        .memory_addr                      (memory_addr),
        .memory_data                      (memory_data),
        .memory_valid                     (memory_valid),
        .output_pc_valid                  (output_pc_valid),
        .output_pc                        (output_pc),
        .output_cc_id                     (output_cc_id),
        .output_pc_is_directed_to_current (output_pc_is_directed_to_current),
        .output_pc_ready                  (output_pc_ready),
        .accepts                          (accepts)
    );

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [7:0] d);
        return {op, 5'b00000, d};
    endfunction

    task automatic push_exp(input logic [7:0] pc, input logic [1:0] cc, input logic dir);
        exp_t e;
        e.pc  = pc;
        e.cc  = cc;
        e.dir = dir;
        exp_q.push_back(e);
    endtask

    // Offers one thread, answers the fetch, then watches outputs until the block is idle again.
    task automatic run_thread(input logic [7:0] pc, input logic [1:0] cc, input logic [15:0] instr,
                              input int mem_delay, input int stall, input int exp_accepts);
        int   acc_cnt;
        int   waited;
        bit   done;
        exp_t e;
        @(negedge clk);
        checks++;
        if (input_pc_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready pc=%h: got %b, expected 1", pc, input_pc_ready);
        end
        input_pc_valid = 1'b1;
        input_pc       = pc;
        input_cc_id    = cc;
        @(negedge clk);
        input_pc_valid = 1'b0;
        for (int i = 0; i <= mem_delay; i++) begin
            checks++;
            if (memory_valid !== 1'b1 || memory_addr !== {3'b000, pc} || input_pc_ready !== 1'b0) begin
                errors++;
                $display("FAIL fetch pc=%h: got valid=%b addr=%h ready=%b, expected valid=1 addr=%h ready=0",
                         pc, memory_valid, memory_addr, input_pc_ready, {3'b000, pc});
            end
            if (i < mem_delay) @(negedge clk);
        end
        memory_ready = 1'b1;
        @(negedge clk);
        memory_ready = 1'b0;
        memory_data  = instr;
        acc_cnt = 0;
        waited  = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            output_pc_ready = 1'b0;
            if (accepts === 1'b1) acc_cnt++;
            checks++;
            if (memory_valid === 1'b1 && input_pc_ready === 1'b1) begin
                errors++;
                $display("FAIL exclusive pc=%h: got memory_valid=1 input_pc_ready=1, expected not both", pc);
            end
            if (output_pc_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output pc=%h: got pc=%h cc=%0d dir=%b, expected no output",
                             pc, output_pc, output_cc_id, output_pc_is_directed_to_current);
                end else begin
                    e = exp_q[0];
                    if (output_pc !== e.pc || output_cc_id !== e.cc ||
                        output_pc_is_directed_to_current !== e.dir || input_pc_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL output pc=%h: got pc=%h cc=%0d dir=%b ready=%b, expected pc=%h cc=%0d dir=%b ready=0",
                                 pc, output_pc, output_cc_id, output_pc_is_directed_to_current,
                                 input_pc_ready, e.pc, e.cc, e.dir);
                    end
                end
                if (waited >= stall) begin
                    output_pc_ready = 1'b1;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    waited = 0;
                end else begin
                    waited++;
                end
            end else if (input_pc_ready === 1'b1) begin
                done = 1'b1;
            end
        end
        output_pc_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout pc=%h: got no return to idle, expected idle within 60 cycles", pc);
        end
        checks++;
        if (acc_cnt != exp_accepts) begin
            errors++;
            $display("FAIL accepts pc=%h: got %0d cycles, expected %0d", pc, acc_cnt, exp_accepts);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_output pc=%h: got %0d outstanding, expected 0", pc, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (input_pc_ready !== 1'b1 || memory_valid !== 1'b0 || output_pc_valid !== 1'b0 ||
            accepts !== 1'b0 || memory_addr !== 11'h000 || output_pc !== 8'h00 ||
            output_cc_id !== 2'd0 || output_pc_is_directed_to_current !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b mv=%b ov=%b acc=%b addr=%h opc=%h cc=%0d dir=%b, expected ready=1 rest 0",
                     input_pc_ready, memory_valid, output_pc_valid, accepts, memory_addr,
                     output_pc, output_cc_id, output_pc_is_directed_to_current);
        end
        reset = 1'b0;
    endtask

    task automatic test_accept();
        current_characters = 32'h44434200;
        run_thread(8'hEF, 2'd0, mk(OP_ACCEPT, 8'h00), 0, 0, 1);
        current_characters = 32'h44434201;
        run_thread(8'hAD, 2'd0, mk(OP_ACCEPT, 8'h00), 1, 0, 0);
        run_thread(8'hAD, 2'd0, mk(OP_ACCEPT_PARTIAL, 8'h00), 0, 0, 1);
        run_thread(8'h33, 2'd0, mk(OP_END, 8'h00), 0, 0, 0);
    endtask

    task automatic test_match();
        current_characters = 32'h64636261;
        push_exp(8'h11, 2'd2, 1'b1);
        run_thread(8'h10, 2'd1, mk(OP_MATCH_CHAR, 8'h62), 0, 1, 0);
        run_thread(8'h10, 2'd1, mk(OP_MATCH_CHAR, 8'h7A), 0, 0, 0);
        push_exp(8'h43, 2'd3, 1'b1);
        run_thread(8'h42, 2'd2, mk(OP_NOT_MATCH_CHAR, 8'h61), 0, 0, 0);
        run_thread(8'h42, 2'd2, mk(OP_NOT_MATCH_CHAR, 8'h63), 0, 0, 0);
        push_exp(8'h78, 2'd2, 1'b1);
        run_thread(8'h50, 2'd2, mk(OP_JMP, 8'h78), 0, 2, 0);
    endtask

    task automatic test_window_end();
        current_characters = 32'h64636261;
        push_exp(8'h31, 2'd0, 1'b0);
        run_thread(8'h30, 2'd3, mk(OP_MATCH_CHAR, 8'h64), 0, 0, 0);
        push_exp(8'h00, 2'd0, 1'b0);
        run_thread(8'hFF, 2'd3, mk(OP_MATCH_CHAR, 8'h64), 0, 0, 0);
        push_exp(8'h61, 2'd0, 1'b0);
        run_thread(8'h60, 2'd3, mk(OP_MATCH_ANY, 8'h00), 0, 0, 0);
        push_exp(8'h62, 2'd1, 1'b1);
        run_thread(8'h61, 2'd0, mk(OP_MATCH_ANY, 8'h00), 0, 0, 0);
    endtask

    task automatic test_split_backpressure();
        current_characters = 32'h64636261;
        push_exp(8'h21, 2'd1, 1'b1);
        push_exp(8'h05, 2'd1, 1'b1);
        run_thread(8'h20, 2'd1, mk(OP_SPLIT, 8'h05), 2, 5, 0);
        push_exp(8'h00, 2'd3, 1'b1);
        push_exp(8'h9C, 2'd3, 1'b1);
        run_thread(8'hFF, 2'd3, mk(OP_SPLIT, 8'h9C), 0, 0, 0);
    endtask

    task automatic test_reset_mid_operation();
        @(negedge clk);
        input_pc_valid = 1'b1;
        input_pc       = 8'h40;
        input_cc_id    = 2'd0;
        @(negedge clk);
        input_pc_valid = 1'b0;
        checks++;
        if (memory_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_fetch: got memory_valid=%b, expected 1", memory_valid);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (memory_valid !== 1'b0 || input_pc_ready !== 1'b1 || output_pc_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got mv=%b ready=%b ov=%b, expected mv=0 ready=1 ov=0",
                     memory_valid, input_pc_ready, output_pc_valid);
        end
        @(negedge clk);
        reset = 1'b0;
        current_characters = 32'h64636261;
        push_exp(8'h51, 2'd1, 1'b1);
        run_thread(8'h50, 2'd0, mk(OP_MATCH_ANY, 8'h00), 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_accept();
        test_match();
        test_window_end();
        test_split_backpressure();
        test_reset_mid_operation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
